// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the demux_1xn_stream block.
//   DEF_WIDTH / DEF_N / DEF_CNTW : default parameter values
//   sel_in_range(sel, n)         : true when a select addresses an existing channel
//   CNT_SAT(w)                   : all-ones saturation value of a w-bit counter
package demux_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_N     = 8;
  localparam int unsigned DEF_CNTW  = 16;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

  function automatic logic [63:0] CNT_SAT(input int unsigned w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/demux_1xn_stream_if.sv
// demux_1xn_stream_if: stream bundle between one producer, the demux and N consumers.
//   in_data/in_sel/in_valid -> demux, in_ready <- demux
//   out_data/out_valid <- demux (channel i at [i*WIDTH +: WIDTH]), out_ready -> demux
// Modports: master = producer/consumer side, slave = demux side.
interface demux_1xn_stream_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N     = DEF_N,
  parameter int unsigned SELW  = $clog2(N)
) ();

  logic [WIDTH-1:0]   in_data;
  logic [SELW-1:0]    in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register for a single output channel.
//   clk, rst_n : clock, async active-low reset
//   i_load     : write i_data this cycle (wins over a drain)
//   i_data     : word to store
//   i_ready    : consumer accepts the held word
//   o_valid    : slot holds a word
//   o_data     : held word (keeps last value when empty)
module demux_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/demux_1xn_stream.sv
// demux_1xn_stream: registered 1-to-N stream demultiplexer with per-channel
// one-entry slots, out-of-range select detection and a saturating drop counter.
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : stream bundle (slave side), see demux_1xn_stream_if
//   in_bcast   : (only with DEMUX_BROADCAST_EN) load every slot, ignore in_sel
//   sel_err    : one-cycle pulse after an out-of-range word was dropped
//   drop_cnt   : saturating count of dropped words
// Optional feature macro: DEMUX_BROADCAST_EN.
module demux_1xn_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N     = DEF_N,
  parameter int unsigned SELW  = $clog2(N),
  parameter int unsigned CNTW  = DEF_CNTW
) (
  input  logic            clk,
  input  logic            rst_n,
  demux_1xn_stream_if.slave bus,
`ifdef DEMUX_BROADCAST_EN
  input  logic            in_bcast,
`endif
  output logic            sel_err,
  output logic [CNTW-1:0] drop_cnt
);

  localparam logic [CNTW-1:0] LP_CNT_SAT = CNTW'(CNT_SAT(CNTW));

  logic [N-1:0]       w_sel_hit;
  logic [N-1:0]       w_slot_free;
  logic [N-1:0]       w_load;
  logic [N-1:0]       w_valid;
  logic [N*WIDTH-1:0] w_data;
  logic               w_in_range;
  logic               w_bcast;
  logic               w_in_ready;
  logic               w_xfer;
  logic               w_drop;

  logic               r_sel_err;
  logic [CNTW-1:0]    r_drop_cnt;

`ifdef DEMUX_BROADCAST_EN
  assign w_bcast = in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  // One-hot decode; an out-of-range select decodes to all zeros.
  always_comb begin
    w_sel_hit = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_sel_hit[i] = (bus.in_sel == SELW'(i));
    end
  end

  assign w_in_range  = sel_in_range(32'(bus.in_sel), N);
  // A slot can take a word if it is empty or drains on this same edge.
  assign w_slot_free = ~w_valid | bus.out_ready;

  always_comb begin
    if (w_bcast)          w_in_ready = &w_slot_free;
    else if (!w_in_range) w_in_ready = 1'b1;
    else                  w_in_ready = |(w_sel_hit & w_slot_free);
  end

  assign w_xfer = bus.in_valid && w_in_ready;
  assign w_load = w_xfer ? (w_bcast ? '1 : w_sel_hit) : '0;
  assign w_drop = w_xfer && !w_bcast && !w_in_range;

  for (genvar g = 0; g < N; g++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load[g]),
      .i_data (bus.in_data),
      .i_ready(bus.out_ready[g]),
      .o_valid(w_valid[g]),
      .o_data (w_data[g*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_sel_err <= w_drop;
      if (w_drop && (r_drop_cnt != LP_CNT_SAT)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_data;
  assign sel_err       = r_sel_err;
  assign drop_cnt      = r_drop_cnt;

endmodule
